// File: rtl/player_draw_engine.sv
// Player box pixel engine: erases, moves and repaints an 8x8 box by issuing one VGA pixel write per cycle.
// Optional PLAYER_WRAP_EN: moves wrap around the screen edges instead of clamping.
module player_draw_engine #(
    parameter int         BOX_W     = 8,
    parameter int         BOX_H     = 8,
    parameter int         STEP      = 4,
    parameter int         X_INIT    = 76,
    parameter int         Y_INIT    = 56,
    parameter logic [2:0] FG_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] STATE,
    output logic       doneDrawing,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);
    localparam logic [3:0] CMD_HOLD    = 4'b0000;
    localparam logic [3:0] CMD_PREHOLD = 4'b0100;
    localparam logic [3:0] CMD_CLEAR   = 4'b0001;
    localparam logic [3:0] CMD_RIGHT   = 4'b0010;
    localparam logic [3:0] CMD_LEFT    = 4'b0011;
    localparam logic [3:0] CMD_DOWN    = 4'b0110;
    localparam logic [3:0] CMD_UP      = 4'b0111;
    localparam logic [3:0] CMD_DRAW    = 4'b0101;

    localparam int         CXW    = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int         CYW    = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [8:0] X_MAX  = 9'(160 - BOX_W);
    localparam logic [7:0] Y_MAX  = 8'(120 - BOX_H);
    localparam logic [8:0] STEP_X = 9'(STEP);
    localparam logic [7:0] STEP_Y = 8'(STEP);

    typedef enum logic [1:0] {IDLE, ERASE, PAINT, DONE} phase_t;

    phase_t           phase, phase_nxt;
    logic [7:0]       px, px_nxt;
    logic [6:0]       py, py_nxt;
    logic [8:0]       x_sum;
    logic [7:0]       y_sum;
    logic [CXW-1:0]   cx;
    logic [CYW-1:0]   cy;
    logic [3:0]       done_op;
    logic             scan_last;
    logic             ready, start_erase, start_paint, is_move, is_idle;

    assign ready       = (phase == IDLE) || (phase == DONE);
    assign start_erase = ready && (STATE == CMD_CLEAR) && (done_op != CMD_CLEAR);
    assign start_paint = ready && (STATE == CMD_DRAW) && (done_op != CMD_DRAW);
    assign is_move     = (STATE == CMD_RIGHT) || (STATE == CMD_LEFT) ||
                         (STATE == CMD_DOWN)  || (STATE == CMD_UP);
    assign is_idle     = (STATE == CMD_HOLD) || (STATE == CMD_PREHOLD);

    // Compared against the live command so a stale acknowledge never leaks into the next request.
    assign doneDrawing = (phase == DONE) && (done_op == STATE);

    always_comb begin
        phase_nxt = phase;
        case (phase)
            IDLE, DONE: begin
                if (start_erase)      phase_nxt = ERASE;
                else if (start_paint) phase_nxt = PAINT;
                else if (is_idle)     phase_nxt = IDLE;
            end
            ERASE, PAINT: begin
                if (scan_last) phase_nxt = DONE;
            end
            default: phase_nxt = IDLE;
        endcase
    end

    always_comb begin
        px_nxt = px;
        py_nxt = py;
        x_sum  = {1'b0, px} + STEP_X;
        y_sum  = {1'b0, py} + STEP_Y;
        case (STATE)
`ifdef PLAYER_WRAP_EN
            CMD_RIGHT: px_nxt = (x_sum > X_MAX) ? 8'd0 : x_sum[7:0];
            CMD_LEFT:  px_nxt = ({1'b0, px} >= STEP_X) ? 8'({1'b0, px} - STEP_X) : X_MAX[7:0];
            CMD_DOWN:  py_nxt = (y_sum > Y_MAX) ? 7'd0 : y_sum[6:0];
            CMD_UP:    py_nxt = ({1'b0, py} >= STEP_Y) ? 7'({1'b0, py} - STEP_Y) : Y_MAX[6:0];
`else
            CMD_RIGHT: px_nxt = (x_sum > X_MAX) ? X_MAX[7:0] : x_sum[7:0];
            CMD_LEFT:  px_nxt = ({1'b0, px} >= STEP_X) ? 8'({1'b0, px} - STEP_X) : 8'd0;
            CMD_DOWN:  py_nxt = (y_sum > Y_MAX) ? Y_MAX[6:0] : y_sum[6:0];
            CMD_UP:    py_nxt = ({1'b0, py} >= STEP_Y) ? 7'({1'b0, py} - STEP_Y) : 7'd0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) phase <= IDLE;
        else       phase <= phase_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px        <= 8'(X_INIT);
            py        <= 7'(Y_INIT);
            cx        <= '0;
            cy        <= '0;
            done_op   <= CMD_HOLD;
            scan_last <= 1'b0;
            plot      <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
        end else begin
            plot <= 1'b0;
            if (ready) begin
                if (start_erase || start_paint) begin
                    cx        <= '0;
                    cy        <= '0;
                    scan_last <= 1'b0;
                end else if (is_move) begin
                    px <= px_nxt;
                    py <= py_nxt;
                end else if (is_idle) begin
                    done_op <= CMD_HOLD;
                end
            end else if (scan_last) begin
                // One spare cycle after the last pixel keeps plot and doneDrawing disjoint.
                done_op <= (phase == ERASE) ? CMD_CLEAR : CMD_DRAW;
            end else begin
                plot   <= 1'b1;
                x      <= px + 8'(cx);
                y      <= py + 7'(cy);
                colour <= (phase == ERASE) ? BG_COLOUR : FG_COLOUR;
                if (cx == CXW'(BOX_W - 1)) begin
                    cx <= '0;
                    if (cy == CYW'(BOX_H - 1)) scan_last <= 1'b1;
                    else                       cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_player_draw_engine.sv
// Directed bench for player_draw_engine: fills, moves with clamp (or wrap under PLAYER_WRAP_EN), reset abort.
module tb_player_draw_engine;
    localparam logic [3:0] HOLD  = 4'b0000;
    localparam logic [3:0] CLEAR = 4'b0001;
    localparam logic [3:0] RIGHT = 4'b0010;
    localparam logic [3:0] LEFT  = 4'b0011;
    localparam logic [3:0] DOWN  = 4'b0110;
    localparam logic [3:0] UP    = 4'b0111;
    localparam logic [3:0] DRAW  = 4'b0101;
    localparam logic [2:0] FG    = 3'b100;
    localparam logic [2:0] BG    = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] STATE;
    logic       doneDrawing;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int checks = 0;
    int errors = 0;
    int exp_px, exp_py;
    logic [17:0] exp_q[$];

    player_draw_engine dut (
        .clk(clk), .reset(reset), .STATE(STATE), .doneDrawing(doneDrawing),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int step_pos(input int p, input int maxp, input bit inc);
`ifdef PLAYER_WRAP_EN
        if (inc) return (p + 4 > maxp) ? 0 : p + 4;
        else     return (p >= 4) ? p - 4 : maxp;
`else
        if (inc) return (p + 4 > maxp) ? maxp : p + 4;
        else     return (p >= 4) ? p - 4 : 0;
`endif
    endfunction

    // drivers
    task automatic set_cmd(input logic [3:0] c);
        @(posedge clk);
        #1 STATE = c;
    endtask

    task automatic move(input logic [3:0] c);
        set_cmd(c);
        case (c)
            RIGHT:   exp_px = step_pos(exp_px, 152, 1'b1);
            LEFT:    exp_px = step_pos(exp_px, 152, 1'b0);
            DOWN:    exp_py = step_pos(exp_py, 112, 1'b1);
            default: exp_py = step_pos(exp_py, 112, 1'b0);
        endcase
    endtask

    task automatic fill(input logic [3:0] c, input string tag);
        int plots = 0;
        int first = -1;
        int done_at = -1;
        logic [2:0] col;
        col = (c == CLEAR) ? BG : FG;
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++)
                exp_q.push_back({col, 7'(exp_py + yy), 8'(exp_px + xx)});
        set_cmd(c);
        @(negedge clk);
        check($sformatf("%s req_done_low", tag), 32'(doneDrawing), 32'd0);
        for (int j = 0; j < 100 && done_at < 0; j++) begin
            @(negedge clk);
            if (plot) begin
                plots++;
                if (first < 0) first = j;
                if (exp_q.size() == 0) check($sformatf("%s extra_pixel", tag), 32'd1, 32'd0);
                else check($sformatf("%s pixel%0d", tag, plots - 1), 32'({colour, y, x}), 32'(exp_q.pop_front()));
            end
            if (doneDrawing) begin
                done_at = j;
                check($sformatf("%s plot_in_done", tag), 32'(plot), 32'd0);
            end
        end
        check($sformatf("%s first_plot_cycle", tag), 32'(first), 32'd1);
        check($sformatf("%s done_cycle", tag), 32'(done_at), 32'd65);
        check($sformatf("%s plot_count", tag), 32'(plots), 32'd64);
        check($sformatf("%s missing_pixels", tag), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int plots;
        reset  = 1'b1;
        STATE  = HOLD;
        exp_px = 76;
        exp_py = 56;
        repeat (2) @(negedge clk);
        check("rst plot", 32'(plot), 32'd0);
        check("rst x", 32'(x), 32'd0);
        check("rst y", 32'(y), 32'd0);
        check("rst colour", 32'(colour), 32'd0);
        check("rst done", 32'(doneDrawing), 32'd0);
        reset = 1'b0;

        // draw from reset, then acknowledge must persist while the command holds
        fill(DRAW, "draw0");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("draw0 done_hold", 32'(doneDrawing), 32'd1);
            check("draw0 plot_idle", 32'(plot), 32'd0);
        end

        // erase, step right, repaint
        fill(CLEAR, "clear0");
        move(RIGHT);
        fill(DRAW, "draw1");

        // clear, idle, clear again must redo a full erase
        fill(CLEAR, "clear1");
        set_cmd(HOLD);
        fill(CLEAR, "clear2");

        // right edge: clamp at 152 (or wrap)
        for (int k = 0; k < 20; k++) move(RIGHT);
        set_cmd(HOLD);
        fill(DRAW, "draw_right");

        // left/top edges
        for (int k = 0; k < 45; k++) move(LEFT);
        for (int k = 0; k < 16; k++) move(UP);
        set_cmd(HOLD);
        fill(CLEAR, "clear_corner");

        // bottom edge
        for (int k = 0; k < 30; k++) move(DOWN);
        fill(DRAW, "draw_bottom");

        // reset in the middle of a paint
        set_cmd(HOLD);
        set_cmd(DRAW);
        plots = 0;
        for (int j = 0; j < 100 && plots < 21; j++) begin
            @(negedge clk);
            if (plot) plots++;
        end
        check("abort reached_pixel20", 32'(plots), 32'd21);
        check("abort plot_before", 32'(plot), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort plot_now", 32'(plot), 32'd0);
        STATE = HOLD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort plot_in_reset", 32'(plot), 32'd0);
        end
        reset  = 1'b0;
        exp_px = 76;
        exp_py = 56;
        @(negedge clk);
        check("abort done_low", 32'(doneDrawing), 32'd0);
        check("abort plot_low", 32'(plot), 32'd0);
        fill(DRAW, "draw_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
